// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-stage flip-flop synchroniser for a single asynchronous bit.
// The chain is a pure shift register: nothing sits between stages, which
// gives each stage a full clock period to resolve metastability.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset; every stage loads RESET_VALUE
//   d      in   raw asynchronous input
//   q      out  synchronised output (last stage)
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= {STAGES{RESET_VALUE}};
        end else begin
            stage_reg[0] <= d;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg[gi] <= RESET_VALUE;
                end else begin
                    stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
// Turns a noisy asynchronous input (button, probe line) into a clean level
// in the clk domain. The input is synchronised, then out only follows it
// after the synchronised value has disagreed with out for CLK_WAIT
// consecutive clocks. Registered one-cycle rise/fall strobes accompany each
// change of out.
//
// Ports (positional order: clk, signal, out, rst_n, rise, fall):
//   clk     in   system clock, rising edge
//   signal  in   raw asynchronous input
//   out     out  debounced level
//   rst_n   in   asynchronous active-low reset (release must be clk-synchronous)
//   rise    out  one-clock pulse in the first cycle out reads 1 after a 0
//   fall    out  one-clock pulse in the first cycle out reads 0 after a 1
// ---------------------------------------------------------------------------
module debouncer #(
    parameter int   CLK_WAIT    = 1000,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic signal,
    output logic out,
    input  logic rst_n,
    output logic rise,
    output logic fall
);

    localparam int            CW   = $clog2(CLK_WAIT + 1);
    // Terminal count: reaching it with the input still different commits
    // the new level, so the count itself never wraps.
    localparam logic [CW-1:0] LAST = CW'(CLK_WAIT - 1);

    logic          s_sync;
    logic [CW-1:0] count_reg, count_next;
    logic          out_reg, out_next;
    logic          rise_reg, rise_next;
    logic          fall_reg, fall_next;

    sync_ff #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (signal),
        .q     (s_sync)
    );

    always_comb begin
        count_next = '0;
        out_next   = out_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        // Any agreement between s_sync and out leaves the count at zero,
        // so bounces never accumulate.
        if (s_sync != out_reg) begin
            if (count_reg == LAST) begin
                out_next  = s_sync;
                rise_next = s_sync;
                fall_next = ~s_sync;
            end else begin
                count_next = count_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            out_reg   <= RESET_VALUE;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            out_reg   <= out_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign out  = out_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: tb/tb_debouncer.sv
// Directed bench: one debouncer with CLK_WAIT=5 and one with CLK_WAIT=1,
// SYNC_STAGES=2, RESET_VALUE=0, clock period 4.
module tb_debouncer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sig5  = 1'b0;
    logic sig1  = 1'b0;
    logic out5, rise5, fall5;
    logic out1, rise1, fall1;

    int errors = 0;
    int checks = 0;

    always #2 clk = ~clk;

    debouncer #(.CLK_WAIT(5), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) dut5 (
        .clk(clk), .signal(sig5), .out(out5), .rst_n(rst_n), .rise(rise5), .fall(fall5)
    );

    debouncer #(.CLK_WAIT(1), .SYNC_STAGES(2), .RESET_VALUE(1'b0)) dut1 (
        .clk(clk), .signal(sig1), .out(out1), .rst_n(rst_n), .rise(rise1), .fall(fall1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk5(input string tag, input logic eo, input logic er, input logic ef);
        chk({tag, ".out"},  {7'd0, out5},  {7'd0, eo});
        chk({tag, ".rise"}, {7'd0, rise5}, {7'd0, er});
        chk({tag, ".fall"}, {7'd0, fall5}, {7'd0, ef});
    endtask

    initial begin
        // 1. Reset held with input toggling
        for (int i = 0; i < 6; i++) begin
            sig5 = ~sig5;
            tick();
            chk5("reset_hold", 1'b0, 1'b0, 1'b0);
        end
        sig5 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk5("post_reset", 1'b0, 1'b0, 1'b0);
        end
        chk("post_reset.count", 8'(dut5.count_reg), 8'd0);
        $display("step 1 reset: out5=%b", out5);

        // 2. Bounce rejection: 1 x1, 0 x2, 1 x3, then 0
        sig5 = 1'b1; tick(); chk5("bounce", 1'b0, 1'b0, 1'b0);
        sig5 = 1'b0;
        for (int k = 0; k < 2; k++) begin tick(); chk5("bounce", 1'b0, 1'b0, 1'b0); end
        sig5 = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); chk5("bounce", 1'b0, 1'b0, 1'b0); end
        sig5 = 1'b0;
        for (int k = 0; k < 10; k++) begin tick(); chk5("bounce", 1'b0, 1'b0, 1'b0); end
        $display("step 2 bounce: out5=%b", out5);

        // 3. Clean rise: out must change on the 7th edge after the step
        sig5 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk5("clean_rise", (k >= 7), (k == 7), 1'b0);
            if (k == 7) chk("clean_rise.count", 8'(dut5.count_reg), 8'd0);
        end
        $display("step 3 clean rise: out5=%b", out5);

        // 4. Fall with bounce: 0 x4, 1 x1, then 0 held
        sig5 = 1'b0;
        for (int k = 0; k < 4; k++) begin tick(); chk5("fall_bounce", 1'b1, 1'b0, 1'b0); end
        sig5 = 1'b1;
        tick(); chk5("fall_bounce", 1'b1, 1'b0, 1'b0);
        sig5 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk5("clean_fall", (k < 7), 1'b0, (k == 7));
        end
        $display("step 4 clean fall: out5=%b", out5);

        // 5. Reset mid-count
        sig5 = 1'b1;
        for (int k = 0; k < 4; k++) begin tick(); chk5("mid_count", 1'b0, 1'b0, 1'b0); end
        chk("mid_count.count_before", 8'(dut5.count_reg), 8'd2);
        rst_n = 1'b0;
        #1;
        chk5("mid_reset", 1'b0, 1'b0, 1'b0);
        chk("mid_reset.count", 8'(dut5.count_reg), 8'd0);
        tick();
        chk5("mid_reset_hold", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk5("after_reset_rise", (k >= 7), (k == 7), 1'b0);
        end
        $display("step 5 reset mid-count: out5=%b", out5);

        // 6. CLK_WAIT=1: single-cycle pulse appears 3 edges later for 1 cycle
        chk("cw1.idle", {7'd0, out1}, 8'd0);
        sig1 = 1'b1;
        tick();
        sig1 = 1'b0;
        chk("cw1.k1.out", {7'd0, out1}, 8'd0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("cw1.out",  {7'd0, out1},  {7'd0, (k == 3)});
            chk("cw1.rise", {7'd0, rise1}, {7'd0, (k == 3)});
            chk("cw1.fall", {7'd0, fall1}, {7'd0, (k == 4)});
        end
        $display("step 6 clk_wait=1 pulse: out1=%b", out1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
